// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NZCV bit positions and ARM condition-field encodings.
// Imported by the flag/condition unit and by any other condition consumer.
package cpu_pkg;

    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator: 4-bit cond field against NZCV flags.
// Latency: combinational.
// Backpressure: none.
module cond_eval
    import cpu_pkg::*;
#(
    parameter bit NV_PASS = 1'b0
) (
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[F_N];
    assign z = nzcv[F_Z];
    assign c = nzcv[F_C];
    assign v = nzcv[F_V];

    always_comb begin
        pass = NV_PASS;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = NV_PASS;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// NZCV flag register, in-flight flag-op tracking and condition evaluation for issue.
// Latency: condition result 1 cycle after accept; flag writes visible next cycle.
// Backpressure: cond_ready drops on a flag hazard or a held result; issue_ok drops when MAX_PEND ops are in flight.
module flag_cond_unit
    import cpu_pkg::*;
#(
    parameter int MAX_PEND = 3,
    parameter bit BYPASS   = 1'b1,
    parameter bit NV_PASS  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_set,
    output logic       issue_ok,
    input  logic       alu_we,
    input  logic [3:0] alu_nzcv,
    input  logic       msr_we,
    input  logic [3:0] msr_nzcv,
    input  logic       cond_valid,
    input  logic [3:0] cond,
    output logic       cond_ready,
    output logic       res_valid,
    output logic       res_pass,
    input  logic       res_ready,
    output logic [3:0] nzcv_q,
    output logic       c_flag,
    output logic       v_flag,
    output logic       pend_err
);

    localparam int PW = $clog2(MAX_PEND + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);
    localparam logic [PW-1:0] PEND_ONE = PW'(1);

    logic [PW-1:0] pend_cnt;
    logic          byp;
    logic          hz;
    logic          accept;
    logic          eval_pass;
    logic [3:0]    eval_nzcv;

    // A retiring ALU write frees a slot in the same cycle, so it can admit a new issue.
    assign issue_ok   = (pend_cnt < PEND_MAX) | alu_we;
    assign byp        = BYPASS && alu_we;
    assign hz         = (pend_cnt > PEND_ONE) | ((pend_cnt == PEND_ONE) & !byp);
    assign cond_ready = !hz & (!res_valid | res_ready);
    assign accept     = cond_valid & cond_ready;
    assign eval_nzcv  = byp ? alu_nzcv : nzcv_q;

    assign c_flag = nzcv_q[F_C];
    assign v_flag = nzcv_q[F_V];

    cond_eval #(
        .NV_PASS (NV_PASS)
    ) u_cond_eval (
        .cond (cond),
        .nzcv (eval_nzcv),
        .pass (eval_pass)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            nzcv_q <= 4'h0;
        end else if (alu_we) begin
            nzcv_q <= alu_nzcv;
        end else if (msr_we) begin
            nzcv_q <= msr_nzcv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cnt <= '0;
            pend_err <= 1'b0;
        end else begin
            pend_err <= alu_we & !issue_set & (pend_cnt == '0);
            if (issue_set & issue_ok & !alu_we) begin
                pend_cnt <= pend_cnt + PEND_ONE;
            end else if (alu_we & !issue_set & (pend_cnt != '0)) begin
                pend_cnt <= pend_cnt - PEND_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_pass  <= 1'b0;
        end else if (accept) begin
            res_valid <= 1'b1;
            res_pass  <= eval_pass;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed scenarios plus random traffic against a cycle-level reference model of flag_cond_unit.
module tb_flag_cond_unit;

    localparam int MAX_PEND = 3;
    localparam bit BYPASS   = 1'b1;
    localparam bit NV_PASS  = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_set;
    logic       issue_ok;
    logic       alu_we;
    logic [3:0] alu_nzcv;
    logic       msr_we;
    logic [3:0] msr_nzcv;
    logic       cond_valid;
    logic [3:0] cond;
    logic       cond_ready;
    logic       res_valid;
    logic       res_pass;
    logic       res_ready;
    logic [3:0] nzcv_q;
    logic       c_flag;
    logic       v_flag;
    logic       pend_err;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [3:0] m_flags;
    int         m_pend;
    logic       m_rv, m_rp, m_err;
    logic       s_ok, s_rdy;

    always #5 clk = ~clk;

    flag_cond_unit #(
        .MAX_PEND (MAX_PEND),
        .BYPASS   (BYPASS),
        .NV_PASS  (NV_PASS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_set  (issue_set),
        .issue_ok   (issue_ok),
        .alu_we     (alu_we),
        .alu_nzcv   (alu_nzcv),
        .msr_we     (msr_we),
        .msr_nzcv   (msr_nzcv),
        .cond_valid (cond_valid),
        .cond       (cond),
        .cond_ready (cond_ready),
        .res_valid  (res_valid),
        .res_pass   (res_pass),
        .res_ready  (res_ready),
        .nzcv_q     (nzcv_q),
        .c_flag     (c_flag),
        .v_flag     (v_flag),
        .pend_err   (pend_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Conditions come in complementary pairs: odd codes invert the even base test.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return c[0] ? NV_PASS : 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic idle();
        rst = 0; issue_set = 0; alu_we = 0; alu_nzcv = 0; msr_we = 0; msr_nzcv = 0;
        cond_valid = 0; cond = 0; res_ready = 1;
    endtask

    // One clock: check combinational outputs mid-cycle, advance model, check registers after the edge.
    task automatic tick();
        logic exp_ok, exp_rdy, hz, byp, acc;
        logic [3:0] ef;
        #4;
        byp     = BYPASS && alu_we;
        hz      = (m_pend > 1) || (m_pend == 1 && !byp);
        exp_ok  = (m_pend < MAX_PEND) || alu_we;
        exp_rdy = !hz && (!m_rv || res_ready);
        s_ok    = issue_ok;
        s_rdy   = cond_ready;
        chk("issue_ok", issue_ok, exp_ok);
        chk("cond_ready", cond_ready, exp_rdy);
        acc = cond_valid && exp_rdy;
        ef  = byp ? alu_nzcv : m_flags;
        if (rst) begin
            m_flags = 0; m_pend = 0; m_rv = 0; m_rp = 0; m_err = 0;
        end else begin
            m_err = alu_we && !issue_set && (m_pend == 0);
            if (issue_set && exp_ok && !alu_we) m_pend++;
            else if (alu_we && !issue_set && m_pend > 0) m_pend--;
            if (alu_we) m_flags = alu_nzcv;
            else if (msr_we) m_flags = msr_nzcv;
            if (acc) begin
                m_rv = 1; m_rp = ref_pass(cond, ef);
            end else if (res_ready) begin
                m_rv = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("nzcv_q", nzcv_q, m_flags);
        chk("c_flag", c_flag, m_flags[1]);
        chk("v_flag", v_flag, m_flags[0]);
        chk("res_valid", res_valid, m_rv);
        if (m_rv) chk("res_pass", res_pass, m_rp);
        chk("pend_err", pend_err, m_err);
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        m_flags = 0; m_pend = 0; m_rv = 0; m_rp = 0; m_err = 0;
        chk("rst_nzcv", nzcv_q, 4'h0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_pass", res_pass, 1'b0);
        chk("rst_pend_err", pend_err, 1'b0);

        // 1: EQ right after reset, Z=0
        cond_valid = 1; cond = 4'h0;
        tick();
        chk("t1_ready", s_rdy, 1'b1);
        chk("t1_pass", res_pass, 1'b0);

        // 2: MSR sets Z, then EQ/NE/AL/NV
        idle(); msr_we = 1; msr_nzcv = 4'b0100;
        tick();
        chk("t2_flags", nzcv_q, 4'b0100);
        idle(); cond_valid = 1;
        cond = 4'h0; tick(); chk("t2_eq", res_pass, 1'b1);
        cond = 4'h1; tick(); chk("t2_ne", res_pass, 1'b0);
        cond = 4'hE; tick(); chk("t2_al", res_pass, 1'b1);
        cond = 4'hF; tick(); chk("t2_nv", res_pass, 1'b0);

        // 3: stall on pending flags, bypass on the last retire
        idle(); issue_set = 1; tick(); tick();
        idle(); cond_valid = 1; cond = 4'hA; alu_we = 1; alu_nzcv = 4'b1001;
        tick();
        chk("t3_stall", s_rdy, 1'b0);
        alu_nzcv = 4'b1000;
        tick();
        chk("t3_bypass_rdy", s_rdy, 1'b1);
        chk("t3_ge", res_pass, 1'b0);
        chk("t3_valid", res_valid, 1'b1);

        // 4: fill to MAX_PEND, refuse, then issue alongside a retire
        idle(); issue_set = 1; tick(); tick(); tick();
        tick();
        chk("t4_full", s_ok, 1'b0);
        alu_we = 1; alu_nzcv = 4'b0011;
        tick();
        chk("t4_swap_ok", s_ok, 1'b1);
        idle(); cond_valid = 1; cond = 4'hE;
        tick();
        chk("t4_still_full", s_rdy, 1'b0);
        idle(); alu_we = 1; alu_nzcv = 4'b0000; tick(); tick(); tick();

        // 5: ALU wins over MSR
        idle(); alu_we = 1; alu_nzcv = 4'b0010; msr_we = 1; msr_nzcv = 4'b1101;
        issue_set = 1;
        tick();
        chk("t5_nzcv", nzcv_q, 4'b0010);
        chk("t5_c", c_flag, 1'b1);
        chk("t5_v", v_flag, 1'b0);

        // 6: held result under backpressure, then reset while stalled
        idle(); cond_valid = 1; cond = 4'h2; res_ready = 0;
        tick();
        chk("t6_first", res_pass, 1'b1);
        cond = 4'h3;
        tick(); chk("t6_blocked", s_rdy, 1'b0); chk("t6_hold", res_pass, 1'b1);
        tick(); chk("t6_hold2", res_pass, 1'b1);
        issue_set = 1; alu_we = 1; alu_nzcv = 4'hF; msr_we = 1; rst = 1;
        tick();
        chk("t6_rst_nzcv", nzcv_q, 4'h0);
        chk("t6_rst_valid", res_valid, 1'b0);
        chk("t6_rst_pass", res_pass, 1'b0);

        // 7: unexpected ALU write
        idle(); alu_we = 1; alu_nzcv = 4'b0110;
        tick();
        chk("t7_err", pend_err, 1'b1);
        chk("t7_nzcv", nzcv_q, 4'b0110);
        idle(); cond_valid = 1; cond = 4'hE;
        tick();
        chk("t7_err_gone", pend_err, 1'b0);
        chk("t7_no_hazard", s_rdy, 1'b1);

        // 8: every condition against every flag value
        for (int f = 0; f < 16; f++) begin
            idle(); msr_we = 1; msr_nzcv = 4'(f);
            tick();
            idle(); cond_valid = 1;
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c);
                tick();
                chk("sweep", res_pass, ref_pass(4'(c), 4'(f)));
            end
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            issue_set  = ($urandom_range(0, 2) == 0);
            alu_we     = ($urandom_range(0, 2) == 0);
            alu_nzcv   = 4'($urandom);
            msr_we     = ($urandom_range(0, 4) == 0);
            msr_nzcv   = 4'($urandom);
            cond_valid = ($urandom_range(0, 1) == 0);
            cond       = 4'($urandom);
            res_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
